// File: rtl/overcooked_pkg.sv
// Shared kitchen types and tile-grid geometry for the chef/tile-state datapath.
package overcooked_pkg;

    localparam int unsigned X_ORIGIN  = 20;
    localparam int unsigned Y_ORIGIN  = 100;
    localparam int unsigned TILE_SIZE = 40;
    localparam int unsigned NUM_COLS  = 15;
    localparam int unsigned NUM_ROWS  = 8;
    localparam int unsigned ITEM_W    = 3;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned IDX_W     = 7;

    typedef enum logic [ITEM_W-1:0] {
        NONE   = 3'd0,
        ONION  = 3'd1,
        TOMATO = 3'd2,
        PLATE  = 3'd3,
        SOUP   = 3'd4
    } item_t;

    typedef enum logic {
        OpPick = 1'b0,
        OpDrop = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        StIdle,
        StMap,
        StRead,
        StDecide,
        StWrite,
        StResp
    } arb_state_t;

    function automatic logic [1:0] chef_onehot(input logic chef);
        return chef ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/tile_access_arbiter_if.sv
// Chef request/ack bus plus tile-state RAM port of the tile access arbiter.
interface tile_access_arbiter_if;
    import overcooked_pkg::*;

    logic [1:0]         req;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [1:0]         op;
    logic [ITEM_W-1:0]  hold0;
    logic [ITEM_W-1:0]  hold1;
    logic [1:0]         ack;
    logic               success;
    logic [ITEM_W-1:0]  item_out;
    logic [IDX_W-1:0]   tile_idx;
    logic [IDX_W-1:0]   ram_addr;
    logic [ITEM_W-1:0]  ram_rdata;
    logic               ram_we;
    logic [ITEM_W-1:0]  ram_wdata;
    logic               busy;

    modport slave (
        input  req, x0, y0, x1, y1, op, hold0, hold1, ram_rdata,
        output ack, success, item_out, tile_idx, ram_addr, ram_we, ram_wdata, busy
    );

    modport master (
        output req, x0, y0, x1, y1, op, hold0, hold1, ram_rdata,
        input  ack, success, item_out, tile_idx, ram_addr, ram_we, ram_wdata, busy
    );

endinterface

// File: rtl/tile_coord_mapper.sv
// Maps a chef pixel position to a linear tile index and flags positions off the grid.
module tile_coord_mapper
    import overcooked_pkg::*;
(
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               in_bounds_o
);

    localparam logic [COORD_W-1:0] XMin    = COORD_W'(X_ORIGIN);
    localparam logic [COORD_W-1:0] XEnd    = COORD_W'(X_ORIGIN + NUM_COLS * TILE_SIZE);
    localparam logic [COORD_W-1:0] YMin    = COORD_W'(Y_ORIGIN);
    localparam logic [COORD_W-1:0] YEnd    = COORD_W'(Y_ORIGIN + NUM_ROWS * TILE_SIZE);
    localparam logic [COORD_W-1:0] TileSz  = COORD_W'(TILE_SIZE);
    localparam logic [COORD_W-1:0] NumCols = COORD_W'(NUM_COLS);

    logic [COORD_W-1:0] dx, dy, col, row;

    always_comb begin
        in_bounds_o = (x_i >= XMin) && (x_i < XEnd) && (y_i >= YMin) && (y_i < YEnd);
        dx = '0;
        dy = '0;
        // Offsets are only formed on-grid so the unsigned subtraction never wraps.
        if (in_bounds_o) begin
            dx = x_i - XMin;
            dy = y_i - YMin;
        end
        col   = dx / TileSz;
        row   = dy / TileSz;
        idx_o = IDX_W'(col + row * NumCols);
    end

endmodule

// File: rtl/tile_access_arbiter.sv
// Round-robin arbiter serialising both chefs' pick/drop read-modify-writes on the tile RAM.
module tile_access_arbiter
    import overcooked_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_n,
    tile_access_arbiter_if.slave  bus_io
);

    arb_state_t         state_q, state_d;
    logic               last_q, last_d;
    logic               gnt_q, gnt_d;
    logic [1:0]         mask_q, mask_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    op_t                op_q, op_d;
    logic [ITEM_W-1:0]  hold_q, hold_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               succ_q, succ_d;
    logic [ITEM_W-1:0]  item_q, item_d;
    logic [ITEM_W-1:0]  wdata_q, wdata_d;

    logic [1:0]         req_eff;
    logic               grant;
    logic [ITEM_W-1:0]  tile;
    logic [IDX_W-1:0]   map_idx;
    logic               map_in_bounds;

    tile_coord_mapper u_mapper (
        .x_i         (x_q),
        .y_i         (y_q),
        .idx_o       (map_idx),
        .in_bounds_o (map_in_bounds)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            mask_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= OpPick;
            hold_q  <= '0;
            idx_q   <= '0;
            succ_q  <= 1'b0;
            item_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            mask_q  <= mask_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            succ_q  <= succ_d;
            item_q  <= item_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        mask_d  = '0;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        succ_d  = succ_q;
        item_d  = item_q;
        wdata_d = wdata_q;
        req_eff = '0;
        grant   = 1'b0;
        tile    = bus_io.ram_rdata;

        bus_io.ack       = '0;
        bus_io.success   = 1'b0;
        bus_io.item_out  = '0;
        bus_io.tile_idx  = '0;
        bus_io.ram_addr  = '0;
        bus_io.ram_we    = 1'b0;
        bus_io.ram_wdata = '0;
        bus_io.busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                // The chef acked last cycle may still show req; ignore it for one cycle.
                req_eff = bus_io.req & ~mask_q;
                if (req_eff != 2'b00) begin
                    grant   = (req_eff == 2'b11) ? ~last_q : req_eff[1];
                    gnt_d   = grant;
                    last_d  = grant;
                    x_d     = grant ? bus_io.x1 : bus_io.x0;
                    y_d     = grant ? bus_io.y1 : bus_io.y0;
                    op_d    = op_t'(bus_io.op[grant]);
                    hold_d  = grant ? bus_io.hold1 : bus_io.hold0;
                    state_d = StMap;
                end
            end
            StMap: begin
                if (map_in_bounds) begin
                    idx_d   = map_idx;
                    state_d = StRead;
                end else begin
                    idx_d   = '0;
                    succ_d  = 1'b0;
                    item_d  = hold_q;
                    state_d = StResp;
                end
            end
            StRead: begin
                bus_io.ram_addr = idx_q;
                state_d         = StDecide;
            end
            StDecide: begin
                bus_io.ram_addr = idx_q;
                succ_d  = 1'b0;
                item_d  = hold_q;
                wdata_d = '0;
                if (op_q == OpPick) begin
                    if (tile != '0 && hold_q == '0) begin
                        succ_d = 1'b1;
                        item_d = tile;
                    end
                end else if (tile == '0 && hold_q != '0) begin
                    succ_d  = 1'b1;
                    item_d  = '0;
                    wdata_d = hold_q;
                end
                state_d = StWrite;
            end
            StWrite: begin
                bus_io.ram_addr  = idx_q;
                bus_io.ram_we    = succ_q;
                bus_io.ram_wdata = succ_q ? wdata_q : '0;
                state_d          = StResp;
            end
            StResp: begin
                bus_io.ack      = chef_onehot(gnt_q);
                bus_io.success  = succ_q;
                bus_io.item_out = item_q;
                bus_io.tile_idx = idx_q;
                mask_d          = chef_onehot(gnt_q);
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_tile_access_arbiter.sv
// Directed bench for tile_access_arbiter with a transaction-level model checked every cycle.
module tb_tile_access_arbiter;
    import overcooked_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int   raise_gen [2] = '{0, 0};
    int   done_gen  [2] = '{0, 0};
    int   drop_cnt  [2] = '{0, 0};
    int   extra_hold[2] = '{0, 0};

    logic       pre_we = 1'b0;
    logic [6:0] pre_addr = '0;
    logic [2:0] pre_data = '0;
    logic [2:0] mem [0:127];

    tile_access_arbiter_if bus ();

    tile_access_arbiter dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus_io  (bus)
    );

    always #5 clk = ~clk;

    assign bus.req = {raise_gen[1] != done_gen[1], raise_gen[0] != done_gen[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Tile RAM: one-cycle synchronous read, write on ram_we; bench preload port.
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        bus.ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (pre_we) mem[pre_addr] = pre_data;
            else if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    // Chef handshake: drop req after ack (optionally held extra cycles); abandon on reset.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    done_gen[i] = raise_gen[i];
                    drop_cnt[i] = 0;
                end else if (bus.ack[i]) begin
                    drop_cnt[i] = extra_hold[i] + 1;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (drop_cnt[i] > 0) begin
                    drop_cnt[i]--;
                    if (drop_cnt[i] == 0) done_gen[i] = raise_gen[i];
                end
            end
        end
    end

    // Transaction model: each grant yields a known per-cycle output timeline.
    initial begin : model
        int ph, mlen, mg, midx, mitem, mnew, mx, my, mhold, mtl;
        int ex_busy, ex_addr, ex_we, ex_wd, ex_ack, ex_s, ex_item, ex_idx;
        logic mlast, moob, msucc, mop;
        logic [1:0] mmask, eff;
        int mtile [128];
        ph = 0; mlen = 0; mg = 0; midx = 0; mitem = 0; mnew = 0;
        mlast = 1'b1; moob = 1'b0; msucc = 1'b0; mmask = '0;
        for (int i = 0; i < 128; i++) mtile[i] = 0;
        forever begin
            @(negedge clk);
            if (pre_we) mtile[pre_addr] = int'(pre_data);
            ex_busy = 0; ex_addr = 0; ex_we = 0; ex_wd = 0;
            ex_ack = 0; ex_s = 0; ex_item = 0; ex_idx = 0;
            if (!rst_n) begin
                ph = 0; mlast = 1'b1; mmask = '0;
            end else if (ph != 0) begin
                ex_busy = 1;
                if (!moob && ph >= 2 && ph <= 4) ex_addr = midx;
                if (!moob && ph == 4 && msucc) begin
                    ex_we = 1;
                    ex_wd = mnew;
                end
                if (ph == mlen) begin
                    ex_ack  = (mg == 1) ? 2 : 1;
                    ex_s    = int'(msucc);
                    ex_item = mitem;
                    ex_idx  = midx;
                end
            end
            chk("cyc_busy", bus.busy, ex_busy);
            chk("cyc_ram_addr", bus.ram_addr, ex_addr);
            chk("cyc_ram_we", bus.ram_we, ex_we);
            chk("cyc_ram_wdata", bus.ram_wdata, ex_wd);
            chk("cyc_ack", bus.ack, ex_ack);
            chk("cyc_success", bus.success, ex_s);
            chk("cyc_item_out", bus.item_out, ex_item);
            chk("cyc_tile_idx", bus.tile_idx, ex_idx);
            if (rst_n) begin
                if (ph == 0) begin
                    eff = bus.req & ~mmask;
                    mmask = '0;
                    if (eff != 2'b00) begin
                        mg = (eff == 2'b11) ? (mlast ? 0 : 1) : (eff[1] ? 1 : 0);
                        mlast = (mg == 1);
                        mx    = int'(mg == 1 ? bus.x1 : bus.x0);
                        my    = int'(mg == 1 ? bus.y1 : bus.y0);
                        mop   = bus.op[mg];
                        mhold = int'(mg == 1 ? bus.hold1 : bus.hold0);
                        moob  = mx < X_ORIGIN || mx >= X_ORIGIN + NUM_COLS * TILE_SIZE ||
                                my < Y_ORIGIN || my >= Y_ORIGIN + NUM_ROWS * TILE_SIZE;
                        msucc = 1'b0; mitem = mhold; mnew = 0; midx = 0;
                        if (!moob) begin
                            midx = (mx - X_ORIGIN) / TILE_SIZE +
                                   ((my - Y_ORIGIN) / TILE_SIZE) * NUM_COLS;
                            mtl = mtile[midx];
                            if (!mop && mtl != 0 && mhold == 0) begin
                                msucc = 1'b1; mitem = mtl; mnew = 0;
                            end else if (mop && mtl == 0 && mhold != 0) begin
                                msucc = 1'b1; mitem = 0; mnew = mhold;
                            end
                        end
                        mlen = moob ? 2 : 5;
                        ph = 1;
                    end
                end else if (ph == mlen) begin
                    mmask = (mg == 1) ? 2'b10 : 2'b01;
                    ph = 0;
                end else begin
                    if (ph == 4 && msucc) mtile[midx] = mnew;
                    ph++;
                end
            end
        end
    end

    task automatic preload(input int a, input int v);
        @(posedge clk);
        #1;
        pre_addr = 7'(a);
        pre_data = 3'(v);
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic set_chef(input int ch, input int x, input int y, input logic op, input int hold);
        if (ch == 0) begin
            bus.x0 = 10'(x); bus.y0 = 10'(y); bus.hold0 = 3'(hold);
        end else begin
            bus.x1 = 10'(x); bus.y1 = 10'(y); bus.hold1 = 3'(hold);
        end
        bus.op[ch] = op;
    endtask

    task automatic run_one(input int ch, output int lat, output logic [1:0] ack,
                           output logic succ, output logic [2:0] item, output logic [6:0] tidx,
                           output logic [6:0] addr2, output logic we4, output logic [2:0] wd4,
                           output logic any_we, output logic any_addr);
        lat = -1; ack = '0; succ = 1'b0; item = '0; tidx = '0; addr2 = '0;
        we4 = 1'b0; wd4 = '0; any_we = 1'b0; any_addr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        raise_gen[ch]++;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (n == 2) addr2 = bus.ram_addr;
            if (n == 4) begin
                we4 = bus.ram_we;
                wd4 = bus.ram_wdata;
            end
            if (bus.ram_we) any_we = 1'b1;
            if (bus.ram_addr != '0) any_addr = 1'b1;
            if (bus.ack != '0) begin
                lat = n; ack = bus.ack; succ = bus.success;
                item = bus.item_out; tidx = bus.tile_idx;
                break;
            end
        end
    endtask

    task automatic run_pair(output logic [1:0] a1, output logic s1, output logic [2:0] i1,
                            output logic [1:0] a2, output logic s2, output logic [2:0] i2);
        int got;
        got = 0;
        a1 = '0; s1 = 1'b0; i1 = '0; a2 = '0; s2 = 1'b0; i2 = '0;
        repeat (2) @(posedge clk);
        #1;
        raise_gen[0]++;
        raise_gen[1]++;
        for (int n = 0; n < 40 && got < 2; n++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                if (got == 0) begin
                    a1 = bus.ack; s1 = bus.success; i1 = bus.item_out;
                end else begin
                    a2 = bus.ack; s2 = bus.success; i2 = bus.item_out;
                end
                got++;
            end
        end
        chk("pair_ack_count", got, 2);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : main
        int lat, a0n, a1n, a0cnt, a1cnt;
        logic [1:0] ack, a1, a2;
        logic succ, s1, s2, we4, any_we, any_addr, c1s;
        logic [2:0] item, i1, i2, wd4;
        logic [6:0] tidx, addr2;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.op = '0; bus.hold0 = '0; bus.hold1 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_ack", bus.ack, 0);
        rst_n = 1'b1;

        // Chef0 picks an onion off tile 16.
        preload(16, 1);
        set_chef(0, 65, 145, 1'b0, 0);
        run_one(0, lat, ack, succ, item, tidx, addr2, we4, wd4, any_we, any_addr);
        chk("t1_latency", lat, 5);
        chk("t1_ack", ack, 2'b01);
        chk("t1_success", succ, 1);
        chk("t1_item", item, 1);
        chk("t1_tile_idx", tidx, 16);
        chk("t1_addr_n2", addr2, 16);
        chk("t1_we_n4", we4, 1);
        chk("t1_wdata_n4", wd4, 0);
        chk("t1_ram16", mem[16], 0);

        // Chef1 drops onto an occupied corner tile: must fail untouched.
        preload(119, 3);
        set_chef(1, 619, 419, 1'b1, 2);
        run_one(1, lat, ack, succ, item, tidx, addr2, we4, wd4, any_we, any_addr);
        chk("t2_latency", lat, 5);
        chk("t2_ack", ack, 2'b10);
        chk("t2_success", succ, 0);
        chk("t2_item", item, 2);
        chk("t2_tile_idx", tidx, 119);
        chk("t2_no_we", any_we, 0);
        chk("t2_ram119", mem[119], 3);

        // Off-grid pick: short path, RAM untouched.
        set_chef(0, 10, 200, 1'b0, 0);
        run_one(0, lat, ack, succ, item, tidx, addr2, we4, wd4, any_we, any_addr);
        chk("t3_latency", lat, 2);
        chk("t3_ack", ack, 2'b01);
        chk("t3_success", succ, 0);
        chk("t3_no_we", any_we, 0);
        chk("t3_no_addr", any_addr, 0);

        // Reset restores chef0 priority even though chef0 was served last.
        do_reset();
        preload(16, 4);
        set_chef(0, 65, 145, 1'b0, 0);
        set_chef(1, 65, 145, 1'b0, 0);
        run_pair(a1, s1, i1, a2, s2, i2);
        chk("p1_first", a1, 2'b01);
        chk("p1_first_success", s1, 1);
        chk("p1_first_item", i1, 4);
        chk("p1_second", a2, 2'b10);
        chk("p1_second_success", s2, 0);
        chk("p1_second_item", i2, 0);
        run_pair(a1, s1, i1, a2, s2, i2);
        chk("p2_first", a1, 2'b01);
        chk("p2_second", a2, 2'b10);
        set_chef(0, 10, 200, 1'b0, 0);
        run_one(0, lat, ack, succ, item, tidx, addr2, we4, wd4, any_we, any_addr);
        chk("p3_pre_ack", ack, 2'b01);
        set_chef(0, 65, 145, 1'b0, 0);
        run_pair(a1, s1, i1, a2, s2, i2);
        chk("p3_first", a1, 2'b10);
        chk("p3_second", a2, 2'b01);

        // Reset during WRITE: strobe drops at once, no ack, no RAM update.
        preload(16, 1);
        repeat (2) @(posedge clk);
        #1;
        raise_gen[0]++;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (bus.ram_we) break;
        end
        chk("t5_we_before", bus.ram_we, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_we_async", bus.ram_we, 0);
        chk("t5_ack_async", bus.ack, 0);
        chk("t5_busy_async", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t5_busy_after", bus.busy, 0);
        chk("t5_ram16", mem[16], 1);
        run_pair(a1, s1, i1, a2, s2, i2);
        chk("t5_first", a1, 2'b01);
        chk("t5_first_success", s1, 1);
        chk("t5_first_item", i1, 1);

        // Chef0 lingers on req past ack; pending chef1 gets the first IDLE cycle.
        extra_hold[0] = 1;
        set_chef(0, 65, 145, 1'b0, 0);
        set_chef(1, 20, 100, 1'b1, 3);
        a0n = -100; a1n = -100; a0cnt = 0; a1cnt = 0; c1s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        raise_gen[0]++;
        repeat (2) @(posedge clk);
        #1;
        raise_gen[1]++;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.ack[0]) begin
                a0cnt++;
                if (a0n < 0) a0n = n;
            end
            if (bus.ack[1]) begin
                a1cnt++;
                a1n = n;
                c1s = bus.success;
            end
        end
        chk("t6_gap", a1n - a0n, 6);
        chk("t6_chef0_once", a0cnt, 1);
        chk("t6_chef1_once", a1cnt, 1);
        chk("t6_chef1_success", c1s, 1);
        chk("t6_ram0", mem[0], 3);
        extra_hold[0] = 0;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
